// File: rtl/dmem_responder.sv
// Word-organised data memory behind a level-held request / one-cycle ready handshake with a fixed access latency.
// Optional illegal-access detection on err is enabled by defining DMEM_ERR_CHECK_EN.
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        err
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          wr_q, wr_d;
    logic          bad_q, bad_d;
    logic [31:0]   read_data_q;
    logic          err_q;
    logic          req;
    logic          req_bad;
    logic          commit;
    logic [31:0]   mem [DEPTH];

    assign req = mem_read | mem_write;

`ifdef DMEM_ERR_CHECK_EN
    assign req_bad = (address[1:0] != 2'b00) || (address[31:AW+2] != '0) ||
                     (mem_read && mem_write);
`else
    // Without checking the address simply wraps onto the word array.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{address[31:AW+2], address[1:0]};
    assign req_bad = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        bad_d   = bad_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    idx_d   = address[AW+1:2];
                    wdata_d = write_data;
                    wr_d    = mem_write;
                    bad_d   = req_bad;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? DONE : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The _d access fields are the live inputs on a LATENCY=1 accept and the latched copy otherwise.
    assign commit = (state_d == DONE) && (state_q != DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            idx_q       <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            bad_q       <= 1'b0;
            read_data_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            bad_q   <= bad_d;
            err_q   <= commit && bad_d;
            if (commit) begin
                if (bad_d) begin
                    read_data_q <= '0;
                end else if (!wr_d) begin
                    read_data_q <= mem[idx_d];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && commit && wr_d && !bad_d) begin
            mem[idx_d] <= wdata_d;
        end
    end

    assign read_data = read_data_q;
    assign ready     = (state_q == DONE);
    assign err       = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: LATENCY=2 and LATENCY=1 instances, directed table, corner sequences, random ops vs model.
module tb_dmem_responder;
`ifdef DMEM_ERR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    localparam int LAT0 = 2;
    localparam int LAT1 = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_s   [2];
    logic        wr_s   [2];
    logic [31:0] addr_s [2];
    logic [31:0] wd_s   [2];
    logic [31:0] rdat_s [2];
    logic        rdy_s  [2];
    logic        err_s  [2];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(256), .LATENCY(LAT0)) dut (
        .clk(clk), .rst(rst), .mem_read(rd_s[0]), .mem_write(wr_s[0]),
        .address(addr_s[0]), .write_data(wd_s[0]), .read_data(rdat_s[0]),
        .ready(rdy_s[0]), .err(err_s[0])
    );

    dmem_responder #(.DEPTH(256), .LATENCY(LAT1)) dut1 (
        .clk(clk), .rst(rst), .mem_read(rd_s[1]), .mem_write(wr_s[1]),
        .address(addr_s[1]), .write_data(wd_s[1]), .read_data(rdat_s[1]),
        .ready(rdy_s[1]), .err(err_s[1])
    );

    // Reference model: plain word array per instance plus the last load value.
    logic [31:0] m_mem      [2][256];
    bit          m_known    [2][256];
    logic [31:0] m_rd       [2];
    bit          m_rd_known [2];

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void model_op(input int u, input logic rd, input logic wr,
                                     input logic [31:0] a, input logic [31:0] d,
                                     output logic e);
        int idx;
        bit bad;
        idx = int'(a[9:2]);
        bad = CHK && ((a[1:0] != 2'b00) || (a[31:10] != 22'd0) || (rd && wr));
        if (bad) begin
            m_rd[u] = '0;
            m_rd_known[u] = 1'b1;
            e = 1'b1;
        end else if (wr) begin
            m_mem[u][idx] = d;
            m_known[u][idx] = 1'b1;
            e = 1'b0;
        end else begin
            m_rd[u] = m_mem[u][idx];
            m_rd_known[u] = m_known[u][idx];
            e = 1'b0;
        end
    endfunction

    function automatic void model_reset();
        for (int u = 0; u < 2; u++) begin
            m_rd[u] = '0;
            m_rd_known[u] = 1'b1;
        end
    endfunction

    // Called #1 after a rising edge with the unit idle; returns #1 after the edge following ready.
    task automatic access(input int u, input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rdat, output logic e,
                          output int lat);
        lat  = 0;
        rdat = '0;
        e    = 1'b0;
        rd_s[u] = rd; wr_s[u] = wr; addr_s[u] = a; wd_s[u] = d;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (rdy_s[u]) begin
                lat  = c;
                rdat = rdat_s[u];
                e    = err_s[u];
                break;
            end
        end
        rd_s[u] = 1'b0; wr_s[u] = 1'b0;
        if (lat == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout unit %0d: ready not seen within 40 cycles, required within %0d", u, (u == 0) ? LAT0 : LAT1);
        end else begin
            @(posedge clk); #1;
            chk("ready_width", {31'd0, rdy_s[u]}, 32'd0);
            chk("err_outside_ready", {31'd0, err_s[u]}, 32'd0);
        end
    endtask

    task automatic run_op(input int u, input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rdat, output logic e);
        logic exp_e;
        int   lat;
        model_op(u, rd, wr, a, d, exp_e);
        access(u, rd, wr, a, d, rdat, e, lat);
        chk("latency", lat, (u == 0) ? LAT0 : LAT1);
        chk("err_model", {31'd0, e}, {31'd0, exp_e});
        if (m_rd_known[u]) chk("rdata_model", rdat, m_rd[u]);
    endtask

    initial begin
        vec_t        tbl[7];
        logic [31:0] rdat;
        logic        e;

        tbl[0] = '{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
        tbl[1] = '{1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 32'h14,  32'h01020304, 32'hDEADBEEF, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 32'h14,  32'h0,        32'h01020304, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 32'h3FC, 32'hA5A5A5A5, 32'hDEADBEEF, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 32'h3FC, 32'h0,        32'hA5A5A5A5, 1'b0};

        for (int u = 0; u < 2; u++) begin
            rd_s[u] = 1'b0; wr_s[u] = 1'b0; addr_s[u] = '0; wd_s[u] = '0;
            for (int i = 0; i < 256; i++) m_known[u][i] = 1'b0;
        end
        model_reset();

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("idle_ready", {31'd0, rdy_s[0]}, 32'd0);
            chk("idle_err", {31'd0, err_s[0]}, 32'd0);
            chk("idle_rdata", rdat_s[0], 32'd0);
            chk("idle_ready_l1", {31'd0, rdy_s[1]}, 32'd0);
        end

        for (int i = 0; i < 7; i++) begin
            run_op(0, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, rdat, e);
            chk($sformatf("tbl%0d_rdata", i), rdat, tbl[i].exp_rdata);
            chk($sformatf("tbl%0d_err", i), {31'd0, e}, {31'd0, tbl[i].exp_err});
        end

        run_op(0, 1'b0, 1'b1, 32'h0, 32'h11111111, rdat, e);
`ifdef DMEM_ERR_CHECK_EN
        run_op(0, 1'b1, 1'b0, 32'h13, 32'h0, rdat, e);
        chk("misaligned_err", {31'd0, e}, 32'd1);
        chk("misaligned_rdata", rdat, 32'd0);
        run_op(0, 1'b0, 1'b1, 32'h400, 32'h77777777, rdat, e);
        chk("oob_write_err", {31'd0, e}, 32'd1);
        run_op(0, 1'b1, 1'b0, 32'h0, 32'h0, rdat, e);
        chk("oob_no_alias", rdat, 32'h11111111);
        run_op(0, 1'b1, 1'b1, 32'h0, 32'h22222222, rdat, e);
        chk("both_err", {31'd0, e}, 32'd1);
`else
        run_op(0, 1'b0, 1'b1, 32'h400, 32'h0000CAFE, rdat, e);
        run_op(0, 1'b1, 1'b0, 32'h0, 32'h0, rdat, e);
        chk("wrap_rdata", rdat, 32'h0000CAFE);
        chk("wrap_err", {31'd0, e}, 32'd0);
`endif

        // LATENCY=1: second read accepted in the IDLE cycle right after the first ready.
        run_op(1, 1'b0, 1'b1, 32'h0, 32'h0BADF00D, rdat, e);
        run_op(1, 1'b0, 1'b1, 32'h4, 32'h600DCAFE, rdat, e);
        rd_s[1] = 1'b1; addr_s[1] = 32'h0;
        @(posedge clk); #1;
        chk("l1_first_ready", {31'd0, rdy_s[1]}, 32'd1);
        chk("l1_first_rdata", rdat_s[1], 32'h0BADF00D);
        addr_s[1] = 32'h4;
        @(posedge clk); #1;
        chk("l1_gap", {31'd0, rdy_s[1]}, 32'd0);
        @(posedge clk); #1;
        chk("l1_second_ready", {31'd0, rdy_s[1]}, 32'd1);
        chk("l1_second_rdata", rdat_s[1], 32'h600DCAFE);
        rd_s[1] = 1'b0;
        @(posedge clk); #1;
        chk("l1_after", {31'd0, rdy_s[1]}, 32'd0);
        m_rd[1] = 32'h600DCAFE;

        // Reset during WAIT drops the pending write.
        run_op(0, 1'b0, 1'b1, 32'h8, 32'h55AA55AA, rdat, e);
        wr_s[0] = 1'b1; addr_s[0] = 32'h8; wd_s[0] = 32'h00001234;
        @(posedge clk); #1;
        chk("rstwait_busy", {31'd0, rdy_s[0]}, 32'd0);
        rst = 1'b1; wr_s[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        chk("rstwait_ready", {31'd0, rdy_s[0]}, 32'd0);
        chk("rstwait_rdata", rdat_s[0], 32'd0);
        @(posedge clk); #1;
        chk("rstwait_no_done", {31'd0, rdy_s[0]}, 32'd0);
        run_op(0, 1'b1, 1'b0, 32'h8, 32'h0, rdat, e);
        chk("rstwait_old_data", rdat, 32'h55AA55AA);

        for (int w = 8; w < 16; w++) run_op(0, 1'b0, 1'b1, 32'(w * 4), $urandom, rdat, e);
        for (int n = 0; n < 150; n++) begin
            logic [31:0] a;
            logic        rd;
            logic        wr;
            int          r;
            a  = 32'($urandom_range(8, 15) * 4);
            r  = int'($urandom_range(0, 7));
            rd = ($urandom_range(0, 1) == 0);
            wr = !rd;
            if (r == 0) a = a | 32'($urandom_range(1, 3));
            if (r == 1) a = a | (32'($urandom_range(1, 255)) << 10);
            if (r == 2) begin rd = 1'b1; wr = 1'b1; end
            run_op(0, rd, wr, a, $urandom, rdat, e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
